ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit that drives the instruction-memory request/response interface and produces the (pc, inst) pair consumed by the IF/ID pipeline register. It is the producer end of the IF→ID path: it holds the PC, keeps at most one fetch outstanding, buffers the returned instruction until the decode side accepts it, and discards stale responses after a control-flow redirect. When no valid instruction is presented, it drives a NOP so the downstream register latches a harmless bubble.

## Interface

- ADDR_WIDTH, 64, PC / fetch address width
- INST_WIDTH, 32, instruction width
- RESET_PC, 64'h8000_0000, PC after reset
- NOP_INST, 32'h0000_0013, instruction driven when out_valid=0 (addi x0,x0,0)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-high
- imem_req_valid  out  1  fetch request present
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  ADDR_WIDTH  fetch address (= internal pc)
- imem_rsp_valid  in  1  instruction returned this cycle
- imem_rsp_data  in  INST_WIDTH  returned instruction
- redirect_valid  in  1  branch/jump/trap redirect, single-cycle pulse
- redirect_pc  in  ADDR_WIDTH  redirect target
- stall  in  1  downstream cannot accept the presented instruction
- out_valid  out  1  out_pc/out_inst carry a fetched instruction
- out_pc  out  ADDR_WIDTH  PC of presented instruction
- out_inst  out  INST_WIDTH  presented instruction, NOP_INST when out_valid=0

## Operation

- State machine: REQ, WAIT, HOLD, DROP. Registers: state, pc, out_pc, out_inst_q, out_valid.
- imem_req_valid = (state==REQ); imem_req_addr = pc; out_inst = out_valid ? out_inst_q : NOP_INST.
- REQ: on imem_req_valid&imem_req_ready → WAIT. Without handshake, imem_req_addr holds stable.
- WAIT: on imem_rsp_valid → capture out_pc<=pc, out_inst_q<=imem_rsp_data, out_valid<=1, pc<=pc+4, → HOLD.
- HOLD: out_valid=1, no request issued. If !stall → out_valid<=0, → REQ (instruction consumed at that edge). If stall → stay, outputs frozen.
- DROP: waits for the stale response; on imem_rsp_valid discard it, → REQ.
- Redirect (highest priority, overrides stall and response capture), pc<=redirect_pc, out_valid<=0 next cycle:
  - REQ without handshake → stay REQ; address changes next cycle (legal: not yet accepted).
  - REQ with handshake same cycle → DROP.
  - WAIT without rsp → DROP; WAIT with rsp same cycle → response discarded, → REQ.
  - HOLD → REQ (held instruction squashed).
  - DROP without rsp → stay DROP; DROP with rsp → REQ.
- imem_rsp_valid in REQ or HOLD is a protocol violation; ignored.
- pc+4 wraps modulo 2^ADDR_WIDTH; redirect_pc used unmodified (no alignment check).
- At most one outstanding request at all times.

## Timing

- Reset (rst high at edge): state=REQ, pc=RESET_PC, out_valid=0, out_pc=0, out_inst_q=0; so next cycle imem_req_valid=1, imem_req_addr=RESET_PC, out_inst=NOP_INST.
- rst has priority over every input, including mid-WAIT/DROP; an in-flight response arriving after reset is then in REQ and ignored.
- Handshake edge N → WAIT from N+1; response earliest in cycle N+1; out_valid rises the cycle after response.
- Zero-wait memory, no stall: 3 cycles per instruction (REQ, WAIT, HOLD).
- Redirect at edge E: out_valid=0 from E+1; request to redirect_pc at E+1 (REQ/WAIT-with-rsp/HOLD/DROP-with-rsp) or after stale response drains (DROP).

## Test plan

- Reset, ready=1, rsp one cycle after accept, data 0xAAAA0001..: out_pc sequence 0x80000000, 0x80000004, 0x80000008; out_valid high 1 cycle in 3.
- Stall held 4 cycles in HOLD: out_pc/out_inst/out_valid frozen, imem_req_valid=0; after release next request at pc+4.
- Redirect to 0x80001000 while WAIT: state DROP, response 0xDEADBEEF discarded (out_valid stays 0), next request addr 0x80001000.
- Redirect same cycle as rsp in WAIT: response discarded, request to target next cycle; redirect in HOLD with stall=1: out_valid=0 next cycle, out_inst=0x00000013.
- imem_req_ready=0 for 5 cycles: imem_req_valid and addr stable; redirect during it changes addr next cycle, no DROP.
- RESET_PC=0xFFFF_FFFF_FFFF_FFFC: second fetch address 0x0 (wrap); rst mid-WAIT → request restarts at RESET_PC, late response ignored.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, keeps at most one imem request in flight,
// holds the returned instruction for decode and squashes stale responses after a redirect.
module ifu_fetch #(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(64'h8000_0000),
    parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  stall,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [INST_WIDTH-1:0] out_inst
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_out_pc;
    logic [INST_WIDTH-1:0] r_out_inst;
    logic                  r_out_valid;
    logic                  w_req_fire;

    assign w_req_fire     = (r_state == S_REQ) && imem_req_ready;
    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = r_pc;
    assign out_valid      = r_out_valid;
    assign out_pc         = r_out_pc;
    assign out_inst       = r_out_valid ? r_out_inst : NOP_INST;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_out_pc    <= '0;
            r_out_inst  <= '0;
            r_out_valid <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect wins over stall and capture; an accepted or pending fetch becomes stale.
            r_pc        <= redirect_pc;
            r_out_valid <= 1'b0;
            case (r_state)
                S_REQ:   r_state <= w_req_fire ? S_DROP : S_REQ;
                S_WAIT:  r_state <= imem_rsp_valid ? S_REQ : S_DROP;
                S_HOLD:  r_state <= S_REQ;
                S_DROP:  r_state <= imem_rsp_valid ? S_REQ : S_DROP;
                default: r_state <= S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_req_fire) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_out_pc    <= r_pc;
                        r_out_inst  <= imem_rsp_data;
                        r_out_valid <= 1'b1;
                        r_pc        <= r_pc + ADDR_WIDTH'(4);
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a transaction-level model of the fetch unit.
module tb_ifu_fetch;

    localparam logic [63:0] NOP = 64'h13;

    logic        clk = 1'b0;
    logic        rst, ready, rsp, redir, stall;
    logic [31:0] data;
    logic [63:0] rpc;
    logic        req_v, o_v;
    logic [63:0] req_a, o_pc;
    logic [31:0] o_inst;

    logic        w_rst, w_ready, w_rsp;
    logic [31:0] w_data;
    logic        w_req_v, w_o_v;
    logic [63:0] w_req_a, w_o_pc;
    logic [31:0] w_o_inst;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_v), .imem_req_ready(ready), .imem_req_addr(req_a),
        .imem_rsp_valid(rsp), .imem_rsp_data(data),
        .redirect_valid(redir), .redirect_pc(rpc), .stall(stall),
        .out_valid(o_v), .out_pc(o_pc), .out_inst(o_inst)
    );

    ifu_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
        .clk(clk), .rst(w_rst),
        .imem_req_valid(w_req_v), .imem_req_ready(w_ready), .imem_req_addr(w_req_a),
        .imem_rsp_valid(w_rsp), .imem_rsp_data(w_data),
        .redirect_valid(1'b0), .redirect_pc(64'h0), .stall(1'b0),
        .out_valid(w_o_v), .out_pc(w_o_pc), .out_inst(w_o_inst)
    );

    // Transaction-level model: fetch in flight, whether it is stale, and the held instruction.
    logic        m_outst, m_stale, m_held;
    logic [63:0] m_pc, m_opc;
    logic [31:0] m_oinst;
    logic        n_outst, n_stale, n_held;
    logic [63:0] n_pc, n_opc;
    logic [31:0] n_oinst;
    logic        m_req;

    assign m_req = !m_outst && !m_held;

    always_comb begin
        n_outst = m_outst;
        n_stale = m_stale;
        n_held  = m_held;
        n_pc    = m_pc;
        n_opc   = m_opc;
        n_oinst = m_oinst;
        if (rst) begin
            n_outst = 1'b0;
            n_stale = 1'b0;
            n_held  = 1'b0;
            n_pc    = 64'h8000_0000;
            n_opc   = 64'h0;
            n_oinst = 32'h0;
        end else if (redir) begin
            n_pc   = rpc;
            n_held = 1'b0;
            if (m_req && ready) begin
                n_outst = 1'b1;
                n_stale = 1'b1;
            end else if (m_outst && rsp) begin
                n_outst = 1'b0;
                n_stale = 1'b0;
            end else if (m_outst) begin
                n_stale = 1'b1;
            end
        end else begin
            if (m_req && ready) begin
                n_outst = 1'b1;
                n_stale = 1'b0;
            end
            if (m_outst && rsp) begin
                n_outst = 1'b0;
                n_stale = 1'b0;
                if (!m_stale) begin
                    n_held  = 1'b1;
                    n_opc   = m_pc;
                    n_oinst = data;
                    n_pc    = m_pc + 64'd4;
                end
            end
            if (m_held && !stall) n_held = 1'b0;
        end
    end

    always @(posedge clk) begin
        m_outst <= n_outst;
        m_stale <= n_stale;
        m_held  <= n_held;
        m_pc    <= n_pc;
        m_opc   <= n_opc;
        m_oinst <= n_oinst;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_req_valid", 64'(req_v), 64'(m_req));
            chk("cmp_req_addr", req_a, m_pc);
            chk("cmp_out_valid", 64'(o_v), 64'(m_held));
            chk("cmp_out_pc", o_pc, m_opc);
            chk("cmp_out_inst", 64'(o_inst), m_held ? 64'(m_oinst) : NOP);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ready = 1'b0; rsp = 1'b0; redir = 1'b0; stall = 1'b0;
    endtask

    bit hs, pend;
    int cnt;

    initial begin
        rst = 1'b1; w_rst = 1'b1;
        clr();
        data = 32'h0; rpc = 64'h0;
        w_ready = 1'b0; w_rsp = 1'b0; w_data = 32'h0;
        tick();
        chk_en = 1'b1;
        tick();

        // Wrap-around instance: fetch at the top of the address space, then reset mid-WAIT.
        w_rst = 1'b0;
        chk("w_reset_addr", w_req_a, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("w_reset_inst", 64'(w_o_inst), NOP);
        w_ready = 1'b1; tick();
        w_ready = 1'b0; w_rsp = 1'b1; w_data = 32'hCAFE_0001; tick();
        w_rsp = 1'b0;
        chk("w_out_pc", w_o_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("w_out_inst", 64'(w_o_inst), 64'hCAFE_0001);
        tick();
        chk("w_wrap_addr", w_req_a, 64'h0);
        chk("w_wrap_req", 64'(w_req_v), 64'h1);
        w_ready = 1'b1; tick();
        w_ready = 1'b0; w_rst = 1'b1; tick();
        w_rst = 1'b0;
        chk("w_rst_addr", w_req_a, 64'hFFFF_FFFF_FFFF_FFFC);
        w_rsp = 1'b1; w_data = 32'h0BAD_0BAD; tick();
        w_rsp = 1'b0;
        chk("w_late_rsp_valid", 64'(w_o_v), 64'h0);
        chk("w_late_rsp_req", 64'(w_req_v), 64'h1);
        chk("w_late_rsp_addr", w_req_a, 64'hFFFF_FFFF_FFFF_FFFC);

        // Main instance out of reset.
        rst = 1'b0;
        chk("reset_req_valid", 64'(req_v), 64'h1);
        chk("reset_addr", req_a, 64'h8000_0000);
        chk("reset_out_valid", 64'(o_v), 64'h0);
        chk("reset_out_inst", 64'(o_inst), NOP);
        chk("reset_out_pc", o_pc, 64'h0);

        // Zero-wait fetches, one valid cycle in three.
        for (int i = 0; i < 3; i++) begin
            ready = 1'b1; tick();
            chk("wait_no_req", 64'(req_v), 64'h0);
            ready = 1'b0; rsp = 1'b1; data = 32'hAAAA_0001 + 32'(i); tick();
            rsp = 1'b0;
            chk("seq_out_pc", o_pc, 64'h8000_0000 + 64'(4 * i));
            chk("seq_out_inst", 64'(o_inst), 64'hAAAA_0001 + 64'(i));
            chk("seq_out_valid", 64'(o_v), 64'h1);
            tick();
            chk("seq_valid_drop", 64'(o_v), 64'h0);
        end
        chk("seq_next_addr", req_a, 64'h8000_000C);

        // Stall while holding.
        ready = 1'b1; tick();
        ready = 1'b0; rsp = 1'b1; data = 32'h1234_5678; tick();
        rsp = 1'b0; stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_out_valid", 64'(o_v), 64'h1);
            chk("stall_out_pc", o_pc, 64'h8000_000C);
            chk("stall_out_inst", 64'(o_inst), 64'h1234_5678);
            chk("stall_no_req", 64'(req_v), 64'h0);
        end
        stall = 1'b0; tick();
        chk("stall_release_addr", req_a, 64'h8000_0010);
        chk("stall_release_req", 64'(req_v), 64'h1);

        // Redirect while waiting: response becomes stale.
        ready = 1'b1; tick();
        ready = 1'b0; redir = 1'b1; rpc = 64'h8000_1000; tick();
        redir = 1'b0;
        chk("drop_no_req", 64'(req_v), 64'h0);
        rsp = 1'b1; data = 32'hDEAD_BEEF; tick();
        rsp = 1'b0;
        chk("drop_out_valid", 64'(o_v), 64'h0);
        chk("drop_next_addr", req_a, 64'h8000_1000);
        chk("model_pc_pin", m_pc, 64'h8000_1000);

        // Redirect coinciding with the response.
        ready = 1'b1; tick();
        ready = 1'b0; rsp = 1'b1; data = 32'h1111_1111; redir = 1'b1; rpc = 64'h8000_2000; tick();
        clr();
        chk("rsp_redir_valid", 64'(o_v), 64'h0);
        chk("rsp_redir_addr", req_a, 64'h8000_2000);
        chk("rsp_redir_req", 64'(req_v), 64'h1);

        // Redirect squashes a stalled held instruction.
        ready = 1'b1; tick();
        ready = 1'b0; rsp = 1'b1; data = 32'h2222_2222; tick();
        rsp = 1'b0; stall = 1'b1; redir = 1'b1; rpc = 64'h8000_3000; tick();
        clr();
        chk("hold_redir_valid", 64'(o_v), 64'h0);
        chk("hold_redir_inst", 64'(o_inst), NOP);
        chk("hold_redir_addr", req_a, 64'h8000_3000);
        chk("model_held_pin", 64'(m_held), 64'h0);

        // Backpressured request, then redirect before acceptance.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_req_valid", 64'(req_v), 64'h1);
            chk("bp_req_addr", req_a, 64'h8000_3000);
        end
        redir = 1'b1; rpc = 64'h8000_4000; tick();
        redir = 1'b0;
        chk("bp_redir_addr", req_a, 64'h8000_4000);
        chk("bp_redir_req", 64'(req_v), 64'h1);

        // Randomized traffic with a 0..2 cycle response latency.
        hs = 1'b0; pend = 1'b0; cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hs) begin
                pend = 1'b1;
                cnt  = $urandom_range(0, 2);
            end
            rsp = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    rsp  = 1'b1;
                    data = $urandom;
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                rsp  = 1'b1;
                data = $urandom;
            end
            ready = ($urandom_range(0, 2) != 0);
            stall = ($urandom_range(0, 2) == 0);
            redir = ($urandom_range(0, 9) == 0);
            rpc   = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                                : {32'h0, $urandom & 32'hFFFF_FFFC};
            @(negedge clk);
            hs = req_v && ready;
            tick();
        end

        clr();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
